uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, the receive counterpart of the team's 8N1 transmitter. It samples an asynchronous RxD line, reconstructs 8-bit frames (start bit, 8 data bits LSB first, 1 stop bit) and presents each byte with a one-cycle valid strobe. It sits beside the transmitter in the top level, driven from the same `clk` and `reset`, and feeds downstream logic or debug pins.

## Interface
- CLKS_PER_BIT, default 10417, number of `clk` cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately, deassertion is synchronous to `clk`.
- RxD  input  1  asynchronous serial line, idle high.
- Data  output  8  last correctly framed byte; holds its value between frames.
- Data_Valid  output  1  one-cycle pulse when `Data` is updated.
- Frame_Error  output  1  one-cycle pulse when the stop bit is sampled low.
- Parity_Error  output  1  one-cycle pulse on parity mismatch; constant 0 unless parity is configured.
- Busy  output  1  high from confirmed start bit until the FSM returns to IDLE.

## Operation
- RxD passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value `rx_s`.
- Bit timer: counter of width ceil(log2(CLKS_PER_BIT)), reloaded on every state change and bit boundary.
- States:
  - IDLE: wait for `rx_s` == 0; then go to START and clear the timer.
  - START: after CLKS_PER_BIT/2 (integer division) cycles, resample. If `rx_s` == 0, assert Busy, clear the bit index and go to DATA. If `rx_s` == 1, treat it as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, shift `rx_s` into bit[index], with index 0 received first. After index 7, go to PARITY if configured, else STOP.
  - PARITY (configured only): after CLKS_PER_BIT cycles, sample and compare with the XOR of the 8 data bits (even parity). Record any mismatch, then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1 and no parity mismatch: load `Data` and pulse Data_Valid.
    - If 1 with a parity mismatch: pulse Parity_Error and leave `Data` unchanged.
    - If 0: pulse Frame_Error, leave `Data` unchanged, and go to BREAK.
    - Otherwise go to IDLE.
  - BREAK: wait for `rx_s` == 1, then go to IDLE. This prevents a held-low line from being decoded as back-to-back 0x00 frames.
- Data_Valid, Frame_Error and Parity_Error are mutually exclusive. Each is high for exactly one cycle per frame, or never.

## Timing
- Reset values: Data = 8'h00, Data_Valid = 0, Frame_Error = 0, Parity_Error = 0, Busy = 0, FSM = IDLE, synchronizer = 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is emitted and `Data` returns to 0.
- Sample point for bit n (start = 0, data = 1..8, stop = 9, or 10 with parity): 2 + CLKS_PER_BIT/2 + n*CLKS_PER_BIT cycles after the first low RxD at the synchronizer input.
- Data_Valid and the error pulses are registered outputs, asserted the cycle after the stop-bit sample.
- Busy falls in the same cycle the strobe rises. The receiver is ready for a new start edge from that cycle, so back-to-back frames with zero idle time are supported.
- Accepts baud mismatch up to ±4% without error.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + 8 data + even parity + stop.
  - The PARITY state exists and Parity_Error is live.
- UART_RX_PARITY_EN undefined:
  - Frame is 8N1 and the PARITY state is not compiled.
  - Parity_Error is tied to 0.

## Test plan
- Reset with RxD high, CLKS_PER_BIT=16: all outputs at reset values; Busy stays 0 for 1000 cycles.
- Send 0xA5 as 8N1: a single Data_Valid pulse with Data = 8'hA5, 2 + 8 + 9*16 + 1 = 155 cycles after the start edge; Frame_Error stays 0.
- Send 0x3C then 0xC3 with zero idle time: two Data_Valid pulses, exactly 160 cycles apart, with the correct bytes.
- Drive a 5-cycle low glitch on RxD: FSM returns to IDLE, no strobe, Busy stays 0. Send 0x00 with the stop bit low, then hold low for 400 cycles: one Frame_Error pulse, Data unchanged, no Data_Valid; the next 0x55 is received correctly after the line returns high.
- Assert reset during data bit 4 of 0xFF: outputs clear immediately; after release, 0x81 is received correctly.
- With UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 gives Data_Valid with Data = 8'h07.
  - 0x07 with parity bit 0 gives a Parity_Error pulse and Data stays 8'h07 from the previous frame.

Source files
------------

// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: UART receiver (start, 8 data bits LSB first, stop) with registered one-cycle strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and a live Parity_Error output. Rev 1.0
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] Data,
  output logic       Data_Valid,
  output logic       Frame_Error,
  output logic       Parity_Error,
  output logic       Busy
);

  localparam int c_TIMER_W = $clog2(CLKS_PER_BIT);
  // Timer compares against count-1 because it restarts at zero on the edge that reloads it.
  localparam logic [c_TIMER_W-1:0] c_HALF_LAST = c_TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_TIMER_W-1:0] c_FULL_LAST = c_TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] w_timer_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nxt;
  logic [7:0]           r_data;
  logic [7:0]           w_data_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_rx;
  logic                 w_half_tick;
  logic                 w_full_tick;
  logic                 w_par_bad;

  assign w_rx        = r_sync2;
  assign w_half_tick = (r_timer == c_HALF_LAST);
  assign w_full_tick = (r_timer == c_FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic w_par_bad_nxt;

  always_comb begin
    w_par_bad_nxt = r_par_bad;
    if (r_state == S_START) begin
      w_par_bad_nxt = 1'b0;
    end else if (r_state == S_PARITY && w_full_tick) begin
      w_par_bad_nxt = (w_rx != ^r_shift);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_bad <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad_nxt;
    end
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (!w_rx) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_half_tick) begin
          w_timer_nxt = '0;
          if (!w_rx) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_full_tick) begin
          w_timer_nxt        = '0;
          w_shift_nxt[r_idx] = w_rx;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full_tick) begin
          w_timer_nxt = '0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full_tick) begin
          w_timer_nxt = '0;
          if (!w_rx) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end else begin
            w_state_nxt = S_IDLE;
            if (w_par_bad) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end
          end
        end
      end
      // A line held low after a bad stop bit must not decode as endless 0x00 frames.
      S_BREAK: begin
        w_timer_nxt = '0;
        if (w_rx) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_START);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign Data        = r_data;
  assign Data_Valid  = r_valid;
  assign Frame_Error = r_ferr;
  assign Busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign Parity_Error = r_perr;
`else
  assign Parity_Error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver: randomized frames checked against a frame-level reference model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  // Strobe appears one cycle after the stop-bit sample point.
  localparam int LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       RxD   = 1'b1;
  logic [7:0] Data;
  logic       Data_Valid;
  logic       Frame_Error;
  logic       Parity_Error;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;

  int         obs_cyc[$];
  logic [2:0] obs_kind[$];
  logic [7:0] obs_data[$];
  logic       obs_busy[$];
  int         exp_cyc[$];
  logic [2:0] exp_kind[$];
  logic [7:0] exp_data[$];
  logic       exp_busy[$];
  logic [7:0] m_data = 8'h00;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .RxD          (RxD),
    .Data         (Data),
    .Data_Valid   (Data_Valid),
    .Frame_Error  (Frame_Error),
    .Parity_Error (Parity_Error),
    .Busy         (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Busy) busy_cnt <= busy_cnt + 1;
    if (Data_Valid || Frame_Error || Parity_Error) begin
      obs_cyc.push_back(cyc);
      obs_kind.push_back({Parity_Error, Frame_Error, Data_Valid});
      obs_data.push_back(Data);
      obs_busy.push_back(Busy);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: outcome decided only by stop bit and parity rule.
  function automatic void model_frame(input int start, input logic [7:0] b,
                                      input logic par, input logic stop);
    exp_cyc.push_back(start + LAT);
    if (!stop) begin
      exp_kind.push_back(K_FERR);
      exp_busy.push_back(1'b1);
    end else if (PAR_EN && (par != ^b)) begin
      exp_kind.push_back(K_PERR);
      exp_busy.push_back(1'b0);
    end else begin
      m_data = b;
      exp_kind.push_back(K_VALID);
      exp_busy.push_back(1'b0);
    end
    exp_data.push_back(m_data);
  endfunction

  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int gap);
    int start;
    start = cyc;
    model_frame(start, b, par, stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (PAR_EN) drive(par, CPB);
    drive(stop, CPB);
    if (gap > 0) drive(1'b1, gap);
  endtask

  task automatic compare_events(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "/count"}, obs_cyc.size(), exp_cyc.size());
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
      check({tag, "/cycle"}, obs_cyc[i], exp_cyc[i]);
      check({tag, "/kind"}, 32'(obs_kind[i]), 32'(exp_kind[i]));
      check({tag, "/data"}, 32'(obs_data[i]), 32'(exp_data[i]));
      check({tag, "/busy"}, 32'(obs_busy[i]), 32'(exp_busy[i]));
    end
    check({tag, "/data_hold"}, 32'(Data), 32'(m_data));
    obs_cyc.delete(); obs_kind.delete(); obs_data.delete(); obs_busy.delete();
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete(); exp_busy.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    int         gap;
    int         b0;
    int         start;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(Data), 32'h00);
    check("rst_valid", 32'(Data_Valid), 32'h0);
    check("rst_ferr", 32'(Frame_Error), 32'h0);
    check("rst_perr", 32'(Parity_Error), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);

    reset = 1'b1;
    b0 = busy_cnt;
    drive(1'b1, 1000);
    check("idle_busy_cycles", busy_cnt - b0, 0);
    compare_events("idle");

    send_frame(8'hA5, ^8'hA5, 1'b1, 20);
    compare_events("a5");

    send_frame(8'h3C, ^8'h3C, 1'b1, 0);
    send_frame(8'hC3, ^8'hC3, 1'b1, 20);
    if (obs_cyc.size() >= 2) check("b2b_spacing", obs_cyc[1] - obs_cyc[0], NBITS * CPB);
    compare_events("b2b");

    b0 = busy_cnt;
    drive(1'b0, 5);
    drive(1'b1, 40);
    check("glitch_busy_cycles", busy_cnt - b0, 0);
    compare_events("glitch");

    send_frame(8'h00, 1'b0, 1'b0, 0);
    drive(1'b0, 400);
    drive(1'b1, 20);
    compare_events("break");
    send_frame(8'h55, ^8'h55, 1'b1, 20);
    compare_events("after_break");

    // Abort 0xFF in the middle of data bit 4.
    start = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b1, CPB / 2);
    check("midframe_busy", 32'(Busy), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_data", 32'(Data), 32'h00);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_valid", 32'(Data_Valid), 32'h0);
    m_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 3 * CPB);
    compare_events("abort");
    send_frame(8'h81, ^8'h81, 1'b1, 20);
    compare_events("after_abort");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 20);
    compare_events("par_good");
    send_frame(8'h07, 1'b0, 1'b1, 20);
    compare_events("par_bad");
`endif

    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = (^b) ^ ($urandom_range(0, 4) == 0);
      gap  = stop ? int'($urandom_range(0, 30)) : int'($urandom_range(3, 30));
      send_frame(b, par, stop, gap);
    end
    drive(1'b1, 20);
    compare_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
